// File: rtl/pending_priority_encoder_pkg.sv
// Shared constants, FSM state type and a width helper for the pending priority encoder.
package enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pending_priority_encoder_pick_index.sv
// Combinational selector: highest set bit (fixed) or first set bit after start_i (round-robin).
module pick_index
  import enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = 3,
  parameter int MODE = MODE_FIXED
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [W-1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    if (MODE == MODE_RR) begin
      // Walk offsets from farthest to nearest so the nearest hit after start_i is kept.
      for (int k = N; k >= 1; k--) begin
        cand = W'((int'(start_i) + k) % N);
        if (vec_i[cand]) begin
          idx_o   = cand;
          found_o = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec_i[i]) begin
          idx_o   = W'(i);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pending_priority_encoder.sv
// Sticky pending register for request pulses, offering one encoded index per valid/ready handshake.
module pending_priority_encoder
  import enc_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODE_FIXED,
  localparam int W    = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         clear_all,
  input  logic         ready_in,
  output logic         valid_out,
  output logic [W-1:0] enc_out,
  output logic [N-1:0] pending,
  output logic         dup_out
);

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d, pending_nx, consume_mask;
  logic [W-1:0] enc_q, enc_d, last_q, last_d, last_nx, pick_idx;
  logic         dup_q, dup_d, hs, pick_found;

  assign hs           = (state_q == OFFER) & ready_in;
  assign consume_mask = hs ? (N'(1) << enc_q) : '0;
  // A request on the bit being consumed wins, so it is re-offered later.
  assign pending_nx   = (pending_q & ~consume_mask) | req_in;
  assign last_nx      = hs ? enc_q : last_q;

  pick_index #(
    .N    (N),
    .W    (W),
    .MODE (MODE)
  ) u_pick (
    .vec_i   (pending_nx),
    .start_i (last_nx),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d   = state_q;
    enc_d     = enc_q;
    pending_d = pending_nx;
    last_d    = last_nx;
    dup_d     = |(req_in & pending_q & ~consume_mask);
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OFFER;
          enc_d   = pick_idx;
        end else begin
          enc_d = '0;
        end
      end
      OFFER: begin
        if (hs) begin
          if (pick_found) begin
            enc_d = pick_idx;
          end else begin
            state_d = IDLE;
            enc_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        enc_d   = '0;
      end
    endcase
    // Flush drops same-cycle requests and any handshake; the round-robin pointer survives.
    if (clear_all) begin
      state_d   = IDLE;
      enc_d     = '0;
      pending_d = '0;
      dup_d     = 1'b0;
      last_d    = last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      enc_q     <= '0;
      pending_q <= '0;
      dup_q     <= 1'b0;
      last_q    <= W'(N - 1);
    end else begin
      state_q   <= state_d;
      enc_q     <= enc_d;
      pending_q <= pending_d;
      dup_q     <= dup_d;
      last_q    <= last_d;
    end
  end

  assign valid_out = (state_q == OFFER);
  assign enc_out   = enc_q;
  assign pending   = pending_q;
  assign dup_out   = dup_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Directed bench: per-cycle vector table on a fixed-priority instance, hand sequences on a round-robin one.
module tb_pending_priority_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       clr = 1'b0;
  logic       rdy = 1'b0;

  logic       fp_valid, fp_dup, rr_valid, rr_dup;
  logic [2:0] fp_enc, rr_enc;
  logic [7:0] fp_pend, rr_pend;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pending_priority_encoder #(.N(8), .MODE(0)) dut_fp (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req),
    .clear_all (clr),
    .ready_in  (rdy),
    .valid_out (fp_valid),
    .enc_out   (fp_enc),
    .pending   (fp_pend),
    .dup_out   (fp_dup)
  );

  pending_priority_encoder #(.N(8), .MODE(1)) dut_rr (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req),
    .clear_all (clr),
    .ready_in  (rdy),
    .valid_out (rr_valid),
    .enc_out   (rr_enc),
    .pending   (rr_pend),
    .dup_out   (rr_dup)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] req;
    logic       clr;
    logic       rdy;
    logic       ev;
    logic [2:0] ee;
    logic [7:0] ep;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic r, input logic [7:0] rq, input logic cl,
                     input logic rd, input logic ev, input logic [2:0] ee, input logic [7:0] ep,
                     input logic ed);
    vec_t v;
    v.name = name; v.rst = r; v.req = rq; v.clr = cl; v.rdy = rd;
    v.ev = ev; v.ee = ee; v.ep = ep; v.ed = ed;
    vecs.push_back(v);
  endtask

  // Inputs apply for one cycle; outputs are sampled 1ns after the edge that registers them.
  task automatic step(input logic r, input logic [7:0] rq, input logic cl, input logic rd);
    rst = r; req = rq; clr = cl; rdy = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    //   name          rst req    clr rdy  valid enc pend  dup
    add("reset0",      1, 8'hFF, 0, 0,   0,  0, 8'h00, 0);
    add("reset1",      1, 8'hFF, 0, 0,   0,  0, 8'h00, 0);
    add("reset_rel",   0, 8'h00, 0, 0,   0,  0, 8'h00, 0);
    add("drain_t1",    0, 8'h0A, 0, 1,   1,  3, 8'h0A, 0);
    add("drain_t2",    0, 8'h00, 0, 1,   1,  1, 8'h02, 0);
    add("drain_t3",    0, 8'h00, 0, 1,   0,  0, 8'h00, 0);
    add("bp_t1",       0, 8'h02, 0, 0,   1,  1, 8'h02, 0);
    add("bp_t2",       0, 8'h80, 0, 0,   1,  1, 8'h82, 0);
    add("bp_t3",       0, 8'h00, 0, 0,   1,  1, 8'h82, 0);
    add("bp_t4",       0, 8'h00, 0, 0,   1,  1, 8'h82, 0);
    add("bp_t5",       0, 8'h00, 0, 0,   1,  1, 8'h82, 0);
    add("bp_t6",       0, 8'h00, 0, 1,   1,  7, 8'h80, 0);
    add("bp_t7",       0, 8'h00, 0, 1,   0,  0, 8'h00, 0);
    add("coal_offer",  0, 8'h20, 0, 0,   1,  5, 8'h20, 0);
    add("coal_dup",    0, 8'h20, 0, 0,   1,  5, 8'h20, 1);
    add("coal_hold",   0, 8'h00, 0, 0,   1,  5, 8'h20, 0);
    add("coal_accept", 0, 8'h00, 0, 1,   0,  0, 8'h00, 0);
    add("coal_gone",   0, 8'h00, 0, 1,   0,  0, 8'h00, 0);
    add("coll_offer",  0, 8'h20, 0, 0,   1,  5, 8'h20, 0);
    add("coll_hs",     0, 8'h20, 0, 1,   1,  5, 8'h20, 0);
    add("coll_accept", 0, 8'h00, 0, 1,   0,  0, 8'h00, 0);
    add("rst_offer",   0, 8'h04, 0, 0,   1,  2, 8'h04, 0);
    add("rst_mid",     1, 8'h00, 0, 1,   0,  0, 8'h00, 0);
    add("flush_load",  0, 8'h33, 0, 0,   1,  5, 8'h33, 0);
    add("flush",       0, 8'h10, 1, 1,   0,  0, 8'h00, 0);
    add("flush_after", 0, 8'h00, 0, 0,   0,  0, 8'h00, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].clr, vecs[i].rdy);
      chk($sformatf("%s.valid", vecs[i].name), 64'(fp_valid), 64'(vecs[i].ev));
      chk($sformatf("%s.enc",   vecs[i].name), 64'(fp_enc),   64'(vecs[i].ee));
      chk($sformatf("%s.pend",  vecs[i].name), 64'(fp_pend),  64'(vecs[i].ep));
      chk($sformatf("%s.dup",   vecs[i].name), 64'(fp_dup),   64'(vecs[i].ed));
    end

    // Round-robin: all lines held high yields one index per cycle in rotation.
    step(1, 8'h00, 0, 0);
    step(1, 8'h00, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 8'hFF, 0, 1);
      chk($sformatf("rr_rot%0d.valid", k), 64'(rr_valid), 64'd1);
      chk($sformatf("rr_rot%0d.enc", k), 64'(rr_enc), 64'(k % 8));
    end

    // Round-robin pointer survives a flush, and the flushed handshake does not advance it.
    step(1, 8'h00, 0, 0);
    step(0, 8'h0C, 0, 0);
    chk("rr_ptr_first.enc", 64'(rr_enc), 64'd2);
    step(0, 8'h00, 0, 1);
    chk("rr_ptr_next.enc", 64'(rr_enc), 64'd3);
    step(0, 8'h33, 0, 0);
    chk("rr_ptr_hold.enc", 64'(rr_enc), 64'd3);
    chk("rr_ptr_hold.pend", 64'(rr_pend), 64'h3B);
    step(0, 8'h10, 1, 1);
    chk("rr_flush.valid", 64'(rr_valid), 64'd0);
    chk("rr_flush.pend", 64'(rr_pend), 64'h00);
    chk("rr_flush.dup", 64'(rr_dup), 64'd0);
    step(0, 8'h09, 0, 0);
    chk("rr_after_flush.valid", 64'(rr_valid), 64'd1);
    chk("rr_after_flush.enc", 64'(rr_enc), 64'd3);
    step(0, 8'h00, 0, 1);
    chk("rr_after_flush2.enc", 64'(rr_enc), 64'd0);
    step(0, 8'h00, 0, 1);
    chk("rr_drained.valid", 64'(rr_valid), 64'd0);
    chk("rr_drained.enc", 64'(rr_enc), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
